// File: rtl/bridge_slave_arbiter.sv
// Two-requester round-robin arbiter onto one bridge command port. An in-order
// tag FIFO remembers which requester issued each read so returns route back.
module bridge_slave_arbiter #(
   parameter int ADDR_W    = 25,
   parameter int DATA_W    = 32,
   parameter int TAG_DEPTH = 64,
   parameter int TAG_PTR_W = 6
) (
   input  logic                 slave_clk,
   input  logic                 slave_reset_n,
   input  logic [ADDR_W-1:0]    m0_address,
   input  logic [3:0]           m0_byteenable,
   input  logic                 m0_read,
   input  logic                 m0_write,
   input  logic [DATA_W-1:0]    m0_writedata,
   output logic                 m0_waitrequest,
   output logic [DATA_W-1:0]    m0_readdata,
   output logic                 m0_readdatavalid,
   input  logic [ADDR_W-1:0]    m1_address,
   input  logic [3:0]           m1_byteenable,
   input  logic                 m1_read,
   input  logic                 m1_write,
   input  logic [DATA_W-1:0]    m1_writedata,
   output logic                 m1_waitrequest,
   output logic [DATA_W-1:0]    m1_readdata,
   output logic                 m1_readdatavalid,
   output logic [ADDR_W-1:0]    br_address,
   output logic [3:0]           br_byteenable,
   output logic                 br_read,
   output logic                 br_write,
   output logic [DATA_W-1:0]    br_writedata,
   input  logic                 br_waitrequest,
   input  logic [DATA_W-1:0]    br_readdata,
   input  logic                 br_readdatavalid,
   output logic [TAG_PTR_W:0]   pend_count,
   output logic                 err_orphan_rdv
);
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   localparam logic [TAG_PTR_W:0]   PEND_MAX = (TAG_PTR_W+1)'(TAG_DEPTH);
   localparam logic [TAG_PTR_W:0]   PEND_ONE = (TAG_PTR_W+1)'(1);
   localparam logic [TAG_PTR_W-1:0] PTR_LAST = TAG_PTR_W'(TAG_DEPTH - 1);
   localparam logic [TAG_PTR_W-1:0] PTR_ONE  = TAG_PTR_W'(1);

   state_t               state_q;
   logic                 last_grant_q;
   logic [TAG_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [TAG_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [TAG_PTR_W:0]   pend_q, pend_d;
   logic                 err_q;
   logic                 tag_mem [TAG_DEPTH];

   logic [ADDR_W-1:0]    req_addr  [2];
   logic [3:0]           req_be    [2];
   logic [DATA_W-1:0]    req_wdata [2];
   logic [1:0]           req_rd, req_wr, req_any, req_act, granted, req_wait, rdv;
   logic                 pend_full, grant_vld, grant_idx, accept, push, pop, head_tag;

   assign req_addr[0]  = m0_address;
   assign req_addr[1]  = m1_address;
   assign req_be[0]    = m0_byteenable;
   assign req_be[1]    = m1_byteenable;
   assign req_wdata[0] = m0_writedata;
   assign req_wdata[1] = m1_writedata;
   assign req_rd       = {m1_read, m0_read};
   assign req_wr       = {m1_write, m0_write};

   assign pend_full = (pend_q == PEND_MAX);
   assign pop       = br_readdatavalid & (pend_q != '0);
   assign head_tag  = tag_mem[rd_ptr_q];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign req_any[gi]  = req_rd[gi] | req_wr[gi];
         // A read cannot win arbitration while the tag FIFO is full.
         assign req_act[gi]  = req_wr[gi] | (req_rd[gi] & ~pend_full);
         assign granted[gi]  = grant_vld & (grant_idx == 1'(gi));
         assign req_wait[gi] = req_any[gi] &
                               (~granted[gi] | br_waitrequest | (req_rd[gi] & pend_full));
         assign rdv[gi]      = pop & (head_tag == 1'(gi));
      end
   endgenerate

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 1'b0;
      if (slave_reset_n) begin
         unique case (state_q)
            LOCK0: begin grant_vld = 1'b1; grant_idx = 1'b0; end
            LOCK1: begin grant_vld = 1'b1; grant_idx = 1'b1; end
            default: begin
               grant_vld = |req_act;
               grant_idx = (&req_act) ? ~last_grant_q : req_act[1];
            end
         endcase
      end
   end

   assign br_read       = grant_vld & req_rd[grant_idx] & ~pend_full;
   assign br_write      = grant_vld & req_wr[grant_idx];
   assign br_address    = grant_vld ? req_addr[grant_idx]  : '0;
   assign br_byteenable = grant_vld ? req_be[grant_idx]    : '0;
   assign br_writedata  = grant_vld ? req_wdata[grant_idx] : '0;

   assign accept = (br_read | br_write) & ~br_waitrequest;
   assign push   = accept & br_read;

   assign m0_waitrequest   = req_wait[0];
   assign m1_waitrequest   = req_wait[1];
   assign m0_readdatavalid = rdv[0];
   assign m1_readdatavalid = rdv[1];
   assign m0_readdata      = br_readdata;
   assign m1_readdata      = br_readdata;
   assign pend_count       = pend_q;
   assign err_orphan_rdv   = err_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      pend_d   = pend_q;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      if (push & ~pop)      pend_d = pend_q + PEND_ONE;
      else if (pop & ~push) pend_d = pend_q - PEND_ONE;
   end

   always_ff @(posedge slave_clk) begin
      if (push) tag_mem[wr_ptr_q] <= grant_idx;
   end

   always_ff @(posedge slave_clk or negedge slave_reset_n) begin
      if (!slave_reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         pend_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pend_q   <= pend_d;
         if (br_readdatavalid && pend_q == '0) err_q <= 1'b1;
         if (accept) last_grant_q <= grant_idx;
         unique case (state_q)
            IDLE: begin
               if (grant_vld && br_waitrequest)
                  state_q <= grant_idx ? LOCK1 : LOCK0;
            end
            // A locked requester that withdraws its request releases the lock.
            LOCK0: if (accept || !req_any[0]) state_q <= IDLE;
            LOCK1: if (accept || !req_any[1]) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bridge_slave_arbiter.sv
// Directed bench for bridge_slave_arbiter: arbitration, locking, tag FIFO
// full/return routing, orphan returns and mid-traffic reset.
module tb_bridge_slave_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [24:0] m0_address, m1_address, br_address;
   logic [3:0]  m0_byteenable, m1_byteenable, br_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
   logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic        br_read, br_write, br_waitrequest, br_readdatavalid;
   logic [31:0] br_writedata, br_readdata;
   logic [6:0]  pend_count;
   logic        err_orphan_rdv;

   int n_chk  = 0;
   int n_pass = 0;
   int cnt;

   always #5 clk = ~clk;

   bridge_slave_arbiter dut (
      .slave_clk(clk), .slave_reset_n(rst_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .br_address(br_address), .br_byteenable(br_byteenable), .br_read(br_read),
      .br_write(br_write), .br_writedata(br_writedata), .br_waitrequest(br_waitrequest),
      .br_readdata(br_readdata), .br_readdatavalid(br_readdatavalid),
      .pend_count(pend_count), .err_orphan_rdv(err_orphan_rdv)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      m0_address = '0; m0_byteenable = 4'hF; m0_read = 0; m0_write = 0; m0_writedata = '0;
      m1_address = '0; m1_byteenable = 4'h3; m1_read = 0; m1_write = 0; m1_writedata = '0;
      br_waitrequest = 0; br_readdata = '0; br_readdatavalid = 0;
      tick(); tick();

      // Reset state, with a request and a return presented during reset
      m0_read = 1; br_readdatavalid = 1; #1;
      chk("rst_br_read", br_read, 0);
      chk("rst_br_write", br_write, 0);
      chk("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
      chk("rst_pend", pend_count, 0);
      chk("rst_err", err_orphan_rdv, 0);
      m0_read = 0; br_readdatavalid = 0;
      tick();
      rst_n = 1'b1;
      $display("reset checked");

      // Both read at cycle 0: m0 first, m1 next cycle
      m0_read = 1; m0_address = 25'h10; m1_read = 1; m1_address = 25'h20; #1;
      chk("c0_br_read", br_read, 1);
      chk("c0_addr_m0", br_address, 25'h10);
      chk("c0_be_m0", br_byteenable, 4'hF);
      chk("c0_wait", {m1_waitrequest, m0_waitrequest}, 2'b10);
      tick(); m0_read = 0; #1;
      chk("c1_addr_m1", br_address, 25'h20);
      chk("c1_wait_m1", m1_waitrequest, 0);
      tick(); m1_read = 0; #1;
      chk("c2_pend", pend_count, 2);
      br_readdatavalid = 1; br_readdata = 32'h111; #1;
      chk("ret0_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
      chk("ret0_data", m0_readdata, 32'h111);
      tick(); br_readdata = 32'h222; #1;
      chk("ret1_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
      chk("ret1_data", m1_readdata, 32'h222);
      tick(); br_readdatavalid = 0; #1;
      chk("ret_pend", pend_count, 0);
      $display("dual read arbitration done");

      // m0 write stalled 3 cycles while m1 waits for its read
      m0_write = 1; m0_address = 25'h30; m0_writedata = 32'hDEAD;
      m1_read = 1; m1_address = 25'h40; br_waitrequest = 1; #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("lock_addr%0d", i), br_address, 25'h30);
         chk($sformatf("lock_cmd%0d", i), {br_read, br_write}, 2'b01);
         chk($sformatf("lock_wd%0d", i), br_writedata, 32'hDEAD);
         chk($sformatf("lock_wait%0d", i), {m1_waitrequest, m0_waitrequest}, 2'b11);
         tick();
      end
      br_waitrequest = 0; #1;
      chk("lock_accept", {m1_waitrequest, m0_waitrequest, br_write}, 3'b101);
      tick(); m0_write = 0; #1;
      chk("after_lock_m1", {br_read, m1_waitrequest}, 2'b10);
      chk("after_lock_addr", br_address, 25'h40);
      tick(); m1_read = 0;
      br_readdatavalid = 1; br_readdata = 32'h333; #1;
      chk("lock_ret", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
      tick(); br_readdatavalid = 0;
      $display("lock sequence done");

      // Fill the tag FIFO with m1 reads
      m1_read = 1;
      for (int i = 0; i < 64; i++) begin
         m1_address = 25'(i);
         tick();
      end
      m1_address = 25'h1FF; #1;
      chk("full_pend", pend_count, 64);
      chk("full_br_read", br_read, 0);
      chk("full_m1_wait", m1_waitrequest, 1);
      m0_write = 1; m0_address = 25'h55; #1;
      chk("full_m0_write", {br_write, m0_waitrequest}, 2'b10);
      chk("full_m0_addr", br_address, 25'h55);
      tick(); m0_write = 0;
      br_readdatavalid = 1; br_readdata = 32'h44; #1;
      chk("full_pop_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
      chk("full_still_wait", m1_waitrequest, 1);
      tick(); br_readdatavalid = 0; #1;
      chk("refill_accept", {br_read, m1_waitrequest}, 2'b10);
      tick(); m1_read = 0; #1;
      chk("refill_pend", pend_count, 64);
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         br_readdatavalid = 1; #1;
         if (m1_readdatavalid && !m0_readdatavalid) cnt++;
         tick();
      end
      br_readdatavalid = 0; #1;
      chk("drain_m1_count", 32'(cnt), 64);
      chk("drain_pend", pend_count, 0);
      $display("tag FIFO full sequence done");

      // Interleaved m0,m1,m0 reads; returns A,B,C
      m0_read = 1; m0_address = 25'h1; tick();
      m0_read = 0; m1_read = 1; m1_address = 25'h2; tick();
      m1_read = 0; m0_read = 1; m0_address = 25'h3; tick();
      m0_read = 0; #1;
      chk("ilv_pend", pend_count, 3);
      br_readdatavalid = 1; br_readdata = 32'hA; #1;
      chk("ilv_A", {m1_readdatavalid, m0_readdatavalid, m0_readdata}, {2'b01, 32'hA});
      tick(); br_readdata = 32'hB; #1;
      chk("ilv_B", {m1_readdatavalid, m0_readdatavalid, m1_readdata}, {2'b10, 32'hB});
      tick(); br_readdata = 32'hC; #1;
      chk("ilv_C", {m1_readdatavalid, m0_readdatavalid, m0_readdata}, {2'b01, 32'hC});
      tick(); br_readdatavalid = 0;
      $display("interleaved routing done");

      // Orphan return
      br_readdatavalid = 1; #1;
      chk("orph_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
      tick(); br_readdatavalid = 0; #1;
      chk("orph_err", err_orphan_rdv, 1);
      chk("orph_pend", pend_count, 0);
      tick(); tick(); #1;
      chk("orph_sticky", err_orphan_rdv, 1);
      $display("orphan return done");

      // Reset with 5 pending, then fresh traffic
      m0_read = 1; m0_address = 25'h7;
      for (int i = 0; i < 5; i++) tick();
      m0_read = 0; #1;
      chk("pre_rst_pend", pend_count, 5);
      m0_read = 1; br_readdatavalid = 1; rst_n = 1'b0; #1;
      chk("mid_rst_pend", pend_count, 0);
      chk("mid_rst_err", err_orphan_rdv, 0);
      chk("mid_rst_cmd", {br_read, br_write}, 2'b00);
      chk("mid_rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
      tick();
      rst_n = 1'b1; br_readdatavalid = 0;
      m0_address = 25'h61; m1_read = 1; m1_address = 25'h62; #1;
      chk("post_rst_m0_wins", br_address, 25'h61);
      tick(); m0_read = 0; #1;
      chk("post_rst_m1", br_address, 25'h62);
      tick(); m1_read = 0; #1;
      chk("post_rst_pend", pend_count, 2);
      br_readdatavalid = 1; br_readdata = 32'h5A; #1;
      chk("post_rst_ret0", {m1_readdatavalid, m0_readdatavalid}, 2'b01);
      tick(); br_readdata = 32'h5B; #1;
      chk("post_rst_ret1", {m1_readdatavalid, m0_readdatavalid}, 2'b10);
      tick(); br_readdatavalid = 0; #1;
      chk("post_rst_err", err_orphan_rdv, 0);
      $display("reset with pending tags done");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
